// File: rtl/hamming_secded_codec.sv
// rtl/hamming_secded_codec.sv - streaming Hamming SEC / SEC-DED encoder-decoder with saturating error counters
module hamming_secded_codec #(
  parameter int DATA_W = 8,
  parameter int PAR_W  = 4,
  parameter int SECDED = 1,
  parameter int CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [1:DATA_W+PAR_W+SECDED] in_code,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:DATA_W+PAR_W+SECDED] out_code,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_corr,
  output logic                         out_uncorr,
  output logic [CNT_W-1:0]             corr_cnt,
  output logic [CNT_W-1:0]             uncorr_cnt,
  input  logic                         clr_cnt
);
  localparam int HAM_W  = DATA_W + PAR_W;
  localparam int CODE_W = HAM_W + SECDED;

  // Data bit carried at a non-power-of-two position; data fills those slots MSB first.
  function automatic int data_idx(input int pos);
    int n;
    n = 0;
    for (int q = 1; q < pos; q++) begin
      if ((q & (q - 1)) != 0) n++;
    end
    return DATA_W - 1 - n;
  endfunction

  // Positions whose 1-based index has bit k set: the coverage set of parity bit p_k.
  function automatic logic [1:HAM_W] cover_mask(input int k);
    logic [1:HAM_W] m;
    m = '0;
    for (int p = 1; p <= HAM_W; p++) begin
      m[p] = ((p >> k) & 1) != 0;
    end
    return m;
  endfunction

  logic [1:HAM_W]    enc_raw;
  logic [1:HAM_W]    enc_ham;
  logic [1:CODE_W]   enc_code;
  logic [PAR_W-1:0]  enc_par;
  logic [PAR_W-1:0]  syn;
  logic              ovr;
  logic              syn_big;
  logic [1:CODE_W]   syn_flip;
  logic [1:CODE_W]   dec_fix;
  logic [1:CODE_W]   dec_code;
  logic [DATA_W-1:0] dec_data;
  logic              dec_corr;
  logic              dec_uncorr;
  logic              out_fire;

  logic              out_valid_q, out_valid_d;
  logic [1:CODE_W]   out_code_q, out_code_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_corr_q, out_corr_d;
  logic              out_uncorr_q, out_uncorr_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

  // Position map: parity slots at powers of two, data elsewhere; same map extracts decoded data.
  for (genvar p = 1; p <= HAM_W; p++) begin : g_pos
    if ((p & (p - 1)) == 0) begin : g_par
      assign enc_raw[p] = 1'b0;
      assign enc_ham[p] = enc_par[$clog2(p)];
    end else begin : g_dat
      assign enc_raw[p]            = in_data[data_idx(p)];
      assign enc_ham[p]            = enc_raw[p];
      assign dec_data[data_idx(p)] = dec_code[p];
    end
    assign syn_flip[p] = (syn == PAR_W'(p));
  end

  // Parity generation and syndrome share the coverage masks; syndrome bit k is the
  // parity of every received bit whose index has bit k set.
  for (genvar k = 0; k < PAR_W; k++) begin : g_chk
    localparam logic [1:HAM_W] COVER = cover_mask(k);
    assign enc_par[k] = ^(enc_raw & COVER);
    assign syn[k]     = ^(in_code[1:HAM_W] & COVER);
  end

  if (SECDED != 0) begin : g_secded
    assign enc_code         = {enc_ham, ^enc_ham};
    assign ovr              = ^in_code;
    assign syn_flip[CODE_W] = 1'b0;
  end else begin : g_sec
    assign enc_code = enc_ham;
    assign ovr      = 1'b0;
  end

  assign syn_big = int'(syn) > HAM_W;

  // Classify syndrome and overall parity, and choose which bit (if any) to flip.
  always_comb begin
    dec_fix    = '0;
    dec_corr   = 1'b0;
    dec_uncorr = 1'b0;
    if (syn_big) begin
      dec_uncorr = 1'b1;
    end else if (syn != '0) begin
      if (SECDED == 0 || ovr) begin
        dec_fix  = syn_flip;
        dec_corr = 1'b1;
      end else begin
        // Even number of flips: syndrome points nowhere trustworthy, detect only.
        dec_uncorr = 1'b1;
      end
    end else if (ovr) begin
      // Only the overall parity bit itself is wrong.
      dec_fix  = CODE_W'(1);
      dec_corr = 1'b1;
    end
  end

  assign dec_code = in_code ^ dec_fix;

  assign in_ready = !out_valid_q || out_ready;
  assign out_fire = out_valid_q && out_ready;

  // Next state of the single output slot and the two saturating counters.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_code_d   = out_code_q;
    out_data_d   = out_data_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (in_ready) begin
      out_valid_d = in_valid;
      if (in_valid) begin
        if (in_mode) begin
          out_code_d   = dec_code;
          out_data_d   = dec_data;
          out_corr_d   = dec_corr;
          out_uncorr_d = dec_uncorr;
        end else begin
          out_code_d   = enc_code;
          out_data_d   = in_data;
          out_corr_d   = 1'b0;
          out_uncorr_d = 1'b0;
        end
      end
    end
    if (clr_cnt) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_fire) begin
      if (out_corr_q && corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (out_uncorr_q && uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  // Output slot and counter registers; reset drops any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_code_q   <= '0;
      out_data_q   <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_code_q   <= out_code_d;
      out_data_q   <= out_data_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_code   = out_code_q;
  assign out_data   = out_data_q;
  assign out_corr   = out_corr_q;
  assign out_uncorr = out_uncorr_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// tb/tb_hamming_secded_codec.sv - randomized scoreboard bench for hamming_secded_codec
module tb_hamming_secded_codec;
  typedef struct {
    logic [1:13] code;
    logic [7:0]  data;
    logic        corr;
    logic        uncorr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [7:0]  in_data;
  logic [1:13] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [1:13] out_code;
  logic [7:0]  out_data;
  logic        out_corr;
  logic        out_uncorr;
  logic [7:0]  corr_cnt;
  logic [7:0]  uncorr_cnt;
  logic        clr_cnt;

  int checks;
  int errors;

  exp_t       q[$];
  logic [7:0] m_corr;
  logic [7:0] m_uncorr;

  hamming_secded_codec #(
    .DATA_W(8), .PAR_W(4), .SECDED(1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_data(out_data),
    .out_corr(out_corr), .out_uncorr(out_uncorr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .clr_cnt(clr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_par_pos(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [7:0] m_data(input logic [1:13] c);
    logic [7:0] d;
    int di;
    d = '0;
    di = 7;
    for (int p = 1; p <= 12; p++) begin
      if (!is_par_pos(p)) begin
        d[di] = c[p];
        di--;
      end
    end
    return d;
  endfunction

  function automatic int m_syn(input logic [1:13] c);
    int s;
    s = 0;
    for (int p = 1; p <= 12; p++) if (c[p]) s ^= p;
    return s;
  endfunction

  // Place data, then set exactly the parity bits that cancel the data syndrome.
  function automatic logic [1:13] m_encode(input logic [7:0] d);
    logic [1:13] c;
    int di;
    int s;
    c = '0;
    di = 7;
    for (int p = 1; p <= 12; p++) begin
      if (!is_par_pos(p)) begin
        c[p] = d[di];
        di--;
      end
    end
    s = m_syn(c);
    for (int k = 0; k < 4; k++) c[1 << k] = s[k];
    c[13] = ^c[1:12];
    return c;
  endfunction

  function automatic exp_t m_enc_exp(input logic [7:0] d);
    exp_t e;
    e.code = m_encode(d);
    e.data = d;
    e.corr = 1'b0;
    e.uncorr = 1'b0;
    return e;
  endfunction

  function automatic exp_t m_decode(input logic [1:13] c);
    exp_t e;
    int s;
    logic ovr;
    s = m_syn(c);
    ovr = ^c;
    e.code = c;
    e.corr = 1'b0;
    e.uncorr = 1'b0;
    if (s > 12) e.uncorr = 1'b1;
    else if (s == 0 && ovr) begin
      e.code[13] = ~c[13];
      e.corr = 1'b1;
    end else if (s != 0 && ovr) begin
      e.code[s] = ~c[s];
      e.corr = 1'b1;
    end else if (s != 0) e.uncorr = 1'b1;
    e.data = m_data(e.code);
    return e;
  endfunction

  // Reference model: one-deep result slot and counters, updated at each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_corr <= 8'd0;
      m_uncorr <= 8'd0;
    end else begin
      bit take;
      bit give;
      give = (q.size() != 0) && out_ready;
      take = in_valid && (q.size() == 0 || out_ready);
      if (clr_cnt) begin
        m_corr <= 8'd0;
        m_uncorr <= 8'd0;
      end else if (give) begin
        if (q[0].corr && m_corr != 8'd255) m_corr <= m_corr + 8'd1;
        if (q[0].uncorr && m_uncorr != 8'd255) m_uncorr <= m_uncorr + 8'd1;
      end
      if (give) void'(q.pop_front());
      if (take) q.push_back(in_mode ? m_decode(in_code) : m_enc_exp(in_data));
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
    chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
    chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
    if (q.size() != 0 && out_valid) begin
      chk("out_code", 32'(out_code), 32'(q[0].code));
      chk("out_data", 32'(out_data), 32'(q[0].data));
      chk("out_corr", 32'(out_corr), 32'(q[0].corr));
      chk("out_uncorr", 32'(out_uncorr), 32'(q[0].uncorr));
    end
  end

  task automatic send(input logic mode, input logic [7:0] d, input logic [1:13] c, input bit rnd);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_mode = mode;
    in_data = d;
    in_code = c;
    forever begin
      #1;
      if (in_ready) break;
      @(negedge clk);
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      guard++;
      if (guard > 200) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [1:13] c;
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_mode = 1'b0;
    in_data = 8'h00;
    in_code = '0;
    out_ready = 1'b1;
    clr_cnt = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flags", 32'({out_corr, out_uncorr}), 32'd0);
    chk("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-computed anchors for the model itself.
    chk("pin_enc_00", 32'(m_encode(8'h00)), 32'd0);
    chk("pin_enc_ff", 32'(m_encode(8'hFF)), 32'(13'b1110111011110));
    e = m_decode(13'b1110011011110);
    chk("pin_dec_bit5", 32'({e.code, e.data, e.corr, e.uncorr}), 32'({13'b1110111011110, 8'hFF, 2'b10}));

    // Directed encode/decode cases with literal expectations.
    send(1'b0, 8'h00, '0, 1'b0);
    chk("t1_code", 32'(out_code), 32'd0);
    chk("t1_flags", 32'({out_valid, out_corr, out_uncorr}), 32'b100);
    send(1'b0, 8'hFF, '0, 1'b0);
    chk("t2_enc_code", 32'(out_code), 32'(13'b1110111011110));
    send(1'b1, 8'h00, 13'b1110111011110, 1'b0);
    chk("t2_dec", 32'({out_data, out_corr, out_uncorr}), 32'({8'hFF, 2'b00}));
    send(1'b1, 8'h00, 13'b1110011011110, 1'b0);
    chk("t3_dec", 32'({out_data, out_corr, out_uncorr}), 32'({8'hFF, 2'b10}));
    chk("t3_code", 32'(out_code), 32'(13'b1110111011110));
    @(negedge clk);
    chk("t3_corr_cnt", 32'(corr_cnt), 32'd1);
    send(1'b1, 8'h00, 13'b1110011011010, 1'b0);
    chk("t4_dec", 32'({out_data, out_corr, out_uncorr}), 32'({8'hBD, 2'b01}));
    chk("t4_code", 32'(out_code), 32'(13'b1110011011010));
    @(negedge clk);
    chk("t4_cnts", 32'({corr_cnt, uncorr_cnt}), 32'({8'd1, 8'd1}));

    // Backpressure: first word parked, second word waits with in_valid held.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mode = 1'b0;
    in_data = 8'h5A;
    @(negedge clk);
    c = m_encode(8'hC3);
    c[7] = ~c[7];
    in_mode = 1'b1;
    in_code = c;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_data", 32'(out_data), 32'h5A);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_second", 32'({out_data, out_corr}), 32'({8'hC3, 1'b1}));
    @(negedge clk);

    // Random mix of encodes and clean/1-bit/2-bit/garbage decodes under random backpressure.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      int kind;
      int p1;
      int p2;
      d = 8'($urandom);
      c = m_encode(d);
      kind = int'($urandom_range(0, 4));
      p1 = int'($urandom_range(1, 13));
      p2 = ((p1 - 1 + int'($urandom_range(1, 12))) % 13) + 1;
      if (kind == 1 || kind == 2) c[p1] = ~c[p1];
      if (kind == 2) c[p2] = ~c[p2];
      if (kind == 3) c = 13'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      send(kind != 4, d, c, 1'b1);
      if ($urandom_range(0, 5) == 0) @(negedge clk);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Saturation of the corrected counter, then clear racing an increment.
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    for (int i = 0; i < 260; i++) begin
      c = m_encode(8'($urandom));
      c[$urandom_range(1, 13)] ^= 1'b1;
      send(1'b1, 8'h00, c, 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("sat_corr_cnt", 32'(corr_cnt), 32'd255);
    c = m_encode(8'h96);
    c[2] = ~c[2];
    send(1'b1, 8'h00, c, 1'b0);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_priority", 32'(corr_cnt), 32'd0);

    // Asynchronous reset in the middle of a stream.
    send(1'b0, 8'h77, '0, 1'b0);
    in_valid = 1'b1;
    in_mode = 1'b0;
    in_data = 8'h11;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_code", 32'(out_code), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    c = m_encode(8'h3C);
    c[13] = ~c[13];
    send(1'b1, 8'h00, c, 1'b0);
    chk("post_rst_dec", 32'({out_data, out_corr}), 32'({8'h3C, 1'b1}));
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
